// File: rtl/llki_pkg.sv
// Shared types and constants for the LLKI key sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package llki_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        WAIT_COMPLETE,
        CLEAR_REQ,
        RESP
    } llki_seq_state_t;

    typedef enum logic [2:0] {
        OK             = 3'd0,
        BAD_LEN        = 3'd1,
        EARLY_COMPLETE = 3'd2,
        TIMEOUT        = 3'd3
    } llki_seq_status_t;

    localparam logic LLKI_SEQ_OP_LOAD  = 1'b0;
    localparam logic LLKI_SEQ_OP_CLEAR = 1'b1;

endpackage

// File: rtl/llki_seq_timeout.sv
// Loadable down-counter that flags when a core-side wait has run out of time.
// Latency: expire is combinational from the count; the count itself is registered.
// Backpressure: none; counts only while enabled and holds at zero.
module llki_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] START = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= START;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/llki_key_sequencer.sv
// Drives LOAD/CLEAR commands and a 64-bit key-word stream into one core's LLKI discrete port.
// Latency: kw accept to llkid_key_valid is 1 cycle; every output is a flop.
// Backpressure: one word in flight; kw_ready only in FETCH, response held until rsp_ready.
module llki_key_sequencer
    import llki_pkg::*;
#(
    parameter int MAX_KEY_WORDS  = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [LEN_W-1:0] cmd_num_words,
    input  logic [63:0]      kw_data,
    input  logic             kw_valid,
    output logic             kw_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [63:0]      llkid_key_data,
    output logic             llkid_key_valid,
    input  logic             llkid_key_ready,
    input  logic             llkid_key_complete,
    output logic             llkid_clear_key,
    input  logic             llkid_clear_key_ack
);

    localparam int CNT_W = $clog2(MAX_KEY_WORDS + 1);

    llki_seq_state_t state, state_nxt;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic [CNT_W-1:0] word_len, word_len_nxt;
    logic             cmd_ready_nxt, kw_ready_nxt, rsp_valid_nxt;
    logic             key_valid_nxt, clear_key_nxt;
    logic [2:0]       rsp_status_nxt;
    logic [63:0]      key_data_nxt;
    logic             core_hs, last_word, len_ok;
    logic             timed_cur, timed_nxt, to_expire;

    assign core_hs   = llkid_key_valid && llkid_key_ready;
    assign last_word = (word_cnt + CNT_W'(1)) == word_len;
    assign len_ok    = (cmd_num_words != '0) && (cmd_num_words <= LEN_W'(MAX_KEY_WORDS));

    assign timed_cur = (state == PRESENT) || (state == WAIT_COMPLETE) || (state == CLEAR_REQ);
    assign timed_nxt = (state_nxt == PRESENT) || (state_nxt == WAIT_COMPLETE) ||
                       (state_nxt == CLEAR_REQ);

    llki_seq_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!timed_nxt),
        .load   ((state_nxt != state) || core_hs),
        .en     (timed_cur),
        .expire (to_expire)
    );

    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        word_len_nxt   = word_len;
        cmd_ready_nxt  = cmd_ready;
        kw_ready_nxt   = kw_ready;
        rsp_valid_nxt  = rsp_valid;
        rsp_status_nxt = rsp_status;
        key_data_nxt   = llkid_key_data;
        key_valid_nxt  = llkid_key_valid;
        clear_key_nxt  = llkid_clear_key;

        unique case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    if (cmd_op == LLKI_SEQ_OP_CLEAR) begin
                        state_nxt     = CLEAR_REQ;
                        clear_key_nxt = 1'b1;
                    end else if (len_ok) begin
                        word_len_nxt = cmd_num_words[CNT_W-1:0];
                        word_cnt_nxt = '0;
                        kw_ready_nxt = 1'b1;
                        state_nxt    = FETCH;
                    end else begin
                        rsp_valid_nxt  = 1'b1;
                        rsp_status_nxt = BAD_LEN;
                        state_nxt      = RESP;
                    end
                end
            end

            FETCH: begin
                // A word offered in the same cycle as complete is dropped, not forwarded.
                if (llkid_key_complete) begin
                    kw_ready_nxt   = 1'b0;
                    key_valid_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = EARLY_COMPLETE;
                    state_nxt      = RESP;
                end else if (kw_valid && kw_ready) begin
                    key_data_nxt  = kw_data;
                    key_valid_nxt = 1'b1;
                    kw_ready_nxt  = 1'b0;
                    state_nxt     = PRESENT;
                end
            end

            PRESENT: begin
                if (core_hs) begin
                    key_valid_nxt = 1'b0;
                    word_cnt_nxt  = word_cnt + CNT_W'(1);
                    if (last_word && llkid_key_complete) begin
                        rsp_valid_nxt  = 1'b1;
                        rsp_status_nxt = OK;
                        state_nxt      = RESP;
                    end else if (last_word) begin
                        state_nxt = WAIT_COMPLETE;
                    end else if (llkid_key_complete) begin
                        rsp_valid_nxt  = 1'b1;
                        rsp_status_nxt = EARLY_COMPLETE;
                        state_nxt      = RESP;
                    end else begin
                        kw_ready_nxt = 1'b1;
                        state_nxt    = FETCH;
                    end
                end else if (llkid_key_complete) begin
                    key_valid_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = EARLY_COMPLETE;
                    state_nxt      = RESP;
                end else if (to_expire) begin
                    key_valid_nxt  = 1'b0;
                    key_data_nxt   = '0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = TIMEOUT;
                    state_nxt      = RESP;
                end
            end

            WAIT_COMPLETE: begin
                if (llkid_key_complete) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = OK;
                    state_nxt      = RESP;
                end else if (to_expire) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = TIMEOUT;
                    state_nxt      = RESP;
                end
            end

            CLEAR_REQ: begin
                if (llkid_clear_key_ack) begin
                    clear_key_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = OK;
                    state_nxt      = RESP;
                end else if (to_expire) begin
                    clear_key_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = TIMEOUT;
                    state_nxt      = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            word_cnt        <= '0;
            word_len        <= '0;
            cmd_ready       <= 1'b0;
            kw_ready        <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_status      <= '0;
            llkid_key_data  <= '0;
            llkid_key_valid <= 1'b0;
            llkid_clear_key <= 1'b0;
        end else begin
            state           <= state_nxt;
            word_cnt        <= word_cnt_nxt;
            word_len        <= word_len_nxt;
            cmd_ready       <= cmd_ready_nxt;
            kw_ready        <= kw_ready_nxt;
            rsp_valid       <= rsp_valid_nxt;
            rsp_status      <= rsp_status_nxt;
            llkid_key_data  <= key_data_nxt;
            llkid_key_valid <= key_valid_nxt;
            llkid_clear_key <= clear_key_nxt;
        end
    end

endmodule

// File: doc/llki_key_sequencer.md
Name: llki_key_sequencer

Overview:
Upstream driver for the LLKI discrete key interface of a mock-TSS-wrapped core, such as the FIR filter.
- Accepts LOAD and CLEAR commands from the key-management side, plus a stream of 64-bit key words.
- Sequences those words into the core's llkid_key_data/valid/ready handshake, then waits for llkid_key_complete.
- For CLEAR, runs the llkid_clear_key/ack exchange.
- Returns one status response per command.
- Sits between the LLKI protocol processor and each wrapped core, one instance per core.

Parameters:
- MAX_KEY_WORDS, 8: largest legal LOAD length in 64-bit words.
- TIMEOUT_CYCLES, 1024: cycles without core-side progress before the command aborts with TIMEOUT.
- LEN_W, 8: width of cmd_num_words.

Ports:
- clk  in  1  Core clock.
- rst  in  1  Synchronous, active-high reset.
- cmd_valid  in  1  Command offered.
- cmd_ready  out  1  Command accepted when cmd_valid && cmd_ready.
- cmd_op  in  1  0 = LOAD, 1 = CLEAR.
- cmd_num_words  in  LEN_W  Word count for LOAD; ignored for CLEAR.
- kw_data  in  64  Key word from the upstream stream.
- kw_valid  in  1  Key word offered.
- kw_ready  out  1  Key word accepted when kw_valid && kw_ready.
- rsp_valid  out  1  Response pending.
- rsp_ready  in  1  Response consumed when rsp_valid && rsp_ready.
- rsp_status  out  3  Status code from llki_pkg.
- llkid_key_data  out  64  Key word to the core.
- llkid_key_valid  out  1  Key word presented to the core.
- llkid_key_ready  in  1  Core accepts the word when llkid_key_valid && llkid_key_ready.
- llkid_key_complete  in  1  Core reports its key is fully loaded.
- llkid_clear_key  out  1  Clear request to the core.
- llkid_clear_key_ack  in  1  Core acknowledges the clear.

Behaviour:
Reset (synchronous, rst high at a clock edge):
- State returns to IDLE.
- cmd_ready=0, kw_ready=0, rsp_valid=0, rsp_status=0, llkid_key_data=0, llkid_key_valid=0, llkid_clear_key=0.
- Word counter and timeout counter clear.
- Reset mid-operation abandons the command with no response; no partial state survives.
- All outputs are registered.

States:
- IDLE
  - cmd_ready=1.
  - On accept with CLEAR: go to CLEAR_REQ.
  - On accept with LOAD and 1 <= cmd_num_words <= MAX_KEY_WORDS: latch the length, zero the word counter, go to FETCH.
  - On accept with LOAD and any other length: go to RESP with BAD_LEN. No core-side activity occurs.
- FETCH
  - kw_ready=1.
  - On kw accept: register kw_data into llkid_key_data, raise llkid_key_valid, go to PRESENT.
  - Latency from kw accept to llkid_key_valid high is 1 cycle.
- PRESENT
  - llkid_key_valid and llkid_key_data are held stable until the core handshake.
  - On handshake: drop valid and increment the counter.
  - If counter+1 == length, go to WAIT_COMPLETE; otherwise go to FETCH.
  - kw_ready=0 in this state; there is no word overlap.
- WAIT_COMPLETE
  - llkid_key_complete sampled high: go to RESP with OK.
- CLEAR_REQ
  - llkid_clear_key=1.
  - llkid_clear_key_ack sampled high: drop the request, go to RESP with OK.
- RESP
  - rsp_valid=1 and rsp_status are held until rsp_ready.
  - Then return to IDLE.
  - Earliest next cmd_ready is the cycle after the response handshake.

Error and boundary rules:
- llkid_key_complete sampled high in FETCH or PRESENT:
  - Go to RESP with EARLY_COMPLETE.
  - Drop llkid_key_valid.
  - Do not consume further kw words.
- Timeout counter:
  - Runs in PRESENT, WAIT_COMPLETE and CLEAR_REQ.
  - Clears on entry to each state and on each core handshake.
  - Reaching TIMEOUT_CYCLES-1: abort to RESP with TIMEOUT and deassert all core-side outputs.
  - FETCH has no timeout; upstream starvation is legal.
- Same-cycle precedence:
  - Handshake on the last word together with complete high: treat as OK and go directly to RESP.
  - Handshake and timeout in the same cycle: the handshake wins.
- Counter width is clog2(MAX_KEY_WORDS+1); lengths above MAX_KEY_WORDS never reach it.

Decomposition:
llki_pkg gains:
- llki_seq_state_t enum: IDLE, FETCH, PRESENT, WAIT_COMPLETE, CLEAR_REQ, RESP.
- llki_seq_status_t, 3 bits: OK=0, BAD_LEN=1, EARLY_COMPLETE=2, TIMEOUT=3.
- LLKI_SEQ_OP_LOAD / LLKI_SEQ_OP_CLEAR constants.

One sub-module, llki_seq_timeout: a loadable down-counter with clear and an expire output. Everything else is single-module.

Test Plan:
1. LOAD num_words=1, word 0xDEADBEEF_01234567, core ready 2 cycles after valid, complete 3 cycles later -> llkid_key_data=0xDEADBEEF01234567 stable until handshake, one transfer, rsp_status=OK.
2. LOAD num_words=4, kw_valid gaps of 0/3/1 cycles, core ready always high -> exactly 4 core transfers in order, kw_ready never high in PRESENT, rsp OK.
3. LOAD num_words=0, and separately num_words=9 -> BAD_LEN, llkid_key_valid never asserted, kw_ready never asserted.
4. LOAD num_words=3, complete asserted after the 2nd transfer -> EARLY_COMPLETE, 3rd word not consumed.
5. CLEAR with ack after 5 cycles -> llkid_clear_key high exactly 5 cycles, then OK. Repeat with ack never arriving and TIMEOUT_CYCLES=16 -> TIMEOUT after 16 cycles, clear_key low.
6. rst asserted in PRESENT during LOAD 4 -> next cycle all outputs 0 and cmd_ready=0. One cycle after rst deasserts, cmd_ready=1 and no stale response; rsp_ready held low through a response keeps rsp_valid and rsp_status stable.
